wakeup_arbiter: RTL

WAKEUP_ARBITER -- requirements
Module: wakeup_arbiter

---
 rtl/wakeup_arbiter_pkg.sv | 12 +
 rtl/wakeup_arbiter_if.sv | 25 ++
 rtl/wakeup_arbiter_queue.sv | 46 ++++
 rtl/wakeup_arbiter.sv | 100 ++++++++++
 4 files changed

// File: rtl/wakeup_arbiter_pkg.sv
// Wakeup bus types shared by the wakeup arbiter, Rename and the reservation stations.
package wakeup_arbiter_pkg;

  localparam int TAG_WIDTH   = 6;
  localparam int VALUE_WIDTH = 32;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]   tag;
    logic [VALUE_WIDTH-1:0] value;
  } wakeup_t;

endpackage

// File: rtl/wakeup_arbiter_if.sv
// Per-FU result inputs and the single wakeup broadcast bus; master = FUs/consumers, slave = arbiter.
interface wakeup_arbiter_if
  import wakeup_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [TAG_WIDTH*NUM_REQ-1:0]   req_tag;
  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           wakeup_active;
  logic [TAG_WIDTH-1:0]           wakeup_tag;
  logic [VALUE_WIDTH-1:0]         wakeup_value;
  logic                           busy;

  modport master (
    output req_valid, req_tag, req_value,
    input  req_ready, wakeup_active, wakeup_tag, wakeup_value, busy
  );

  modport slave (
    input  req_valid, req_tag, req_value,
    output req_ready, wakeup_active, wakeup_tag, wakeup_value, busy
  );
endinterface

// File: rtl/wakeup_arbiter_queue.sv
// wakeup_queue: per-requester FIFO of DEPTH wakeup entries (power of two), head shown combinationally.
// Caller never pushes when full nor pops when empty; push+pop together keeps count.
module wakeup_queue
  import wakeup_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wakeup_t       push_dat,
  input  logic          pop,
  output wakeup_t       head,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  wakeup_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/wakeup_arbiter.sv
// Round-robin arbiter of NUM_REQ result queues onto one registered wakeup bus; 2-cycle latency
// (1 cycle with WAKEUP_ARB_BYPASS_EN for a request hitting an empty queue); ready = queue not full.
module wakeup_arbiter
  import wakeup_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int QUEUE_DEPTH = 2
) (
  input logic             clk,
  input logic             reset,
  wakeup_arbiter_if.slave bus
);
  localparam int CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [CW-1:0]      count    [NUM_REQ];
  wakeup_t            head     [NUM_REQ];
  wakeup_t            req_dat  [NUM_REQ];
  wakeup_t            cand     [NUM_REQ];
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] live;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] bypass;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] grant;
  logic               grant_vld;
  logic [PTRW-1:0]    grant_idx;
  logic [PTRW-1:0]    rr_ptr;
  logic               wakeup_active;
  wakeup_t            wakeup_dat;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign req_dat[g]  = {bus.req_tag[TAG_WIDTH*g +: TAG_WIDTH], bus.req_value[VALUE_WIDTH*g +: VALUE_WIDTH]};
    assign nonempty[g] = (count[g] != '0);
    assign ready[g]    = (count[g] < CW'(QUEUE_DEPTH));
    // Tag 0 is accepted but dropped here, so it never queues nor competes.
    assign live[g]     = bus.req_valid[g] & ready[g] & (req_dat[g].tag != '0);
`ifdef WAKEUP_ARB_BYPASS_EN
    assign eligible[g] = nonempty[g] | live[g];
    assign cand[g]     = nonempty[g] ? head[g] : req_dat[g];
    assign bypass[g]   = grant[g] & ~nonempty[g];
`else
    assign eligible[g] = nonempty[g];
    assign cand[g]     = head[g];
    assign bypass[g]   = 1'b0;
`endif
    assign push[g] = live[g] & ~bypass[g];
    assign pop[g]  = grant[g] & nonempty[g];

    wakeup_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk      (clk),
      .reset    (reset),
      .push     (push[g]),
      .push_dat (req_dat[g]),
      .pop      (pop[g]),
      .head     (head[g]),
      .count    (count[g])
    );
  end

  // Walk offsets from far to near so the nearest eligible index after rr_ptr is the last write.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j == (int'(rr_ptr) + k) % NUM_REQ && eligible[j]) begin
          grant_vld = 1'b1;
          grant_idx = PTRW'(j);
          grant     = '0;
          grant[j]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      wakeup_active <= 1'b0;
      wakeup_dat    <= '0;
    end else begin
      wakeup_active <= grant_vld;
      if (grant_vld) begin
        wakeup_dat <= cand[grant_idx];
        rr_ptr     <= (grant_idx == PTRW'(NUM_REQ - 1)) ? '0 : grant_idx + PTRW'(1);
      end
    end
  end

  assign bus.req_ready     = ready;
  assign bus.wakeup_active = wakeup_active;
  assign bus.wakeup_tag    = wakeup_dat.tag;
  assign bus.wakeup_value  = wakeup_dat.value;
  assign bus.busy          = (|nonempty) | wakeup_active;

endmodule
